// File: rtl/multisim_server_chan.sv
`default_nettype none
// ============================================================================
// Module      : multisim_server_chan
// Description : Ready/valid channel buffer. It is a DEPTH-entry FIFO with
//               occupancy reporting and a synchronous flush. Define
//               MULTISIM_SERVER_CHAN_STATS_EN to build the xfer_cnt counter
//               of completed output beats.
// Revision    : 1.0 - initial release
// ============================================================================
module multisim_server_chan #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      count,
    output logic [31:0]           xfer_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [c_ADDR_W:0]     r_wr_ptr;
    logic [c_ADDR_W:0]     r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // The extra pointer MSB separates full from empty when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                     (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);

    assign in_rdy  = !w_full;
    assign out_vld = !w_empty;

    // A flush cycle discards both handshakes.
    assign w_push = in_vld && in_rdy && !flush;
    assign w_pop  = out_vld && out_rdy && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= in_data;
    end

    // Mask the unreset storage so an empty channel presents zero.
    assign out_data = w_empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign count    = CNT_W'(r_wr_ptr - r_rd_ptr);

`ifdef MULTISIM_SERVER_CHAN_STATS_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`else
    assign xfer_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multisim_server_chan.sv
`default_nettype none
// ============================================================================
// Module      : tb_multisim_server_chan
// Description : Directed and random checks of multisim_server_chan against
//               a queue model of a DEPTH-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multisim_server_chan;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_data;
    logic [2:0]  count;
    logic [31:0] xfer_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] q[$];
    int unsigned n_pops   = 0;
    logic [31:0] saved_xfer;

    multisim_server_chan dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_xfer();
`ifdef MULTISIM_SERVER_CHAN_STATS_EN
        return 32'(n_pops);
`else
        return 32'd0;
`endif
    endfunction

    // Compare every output against the model; called away from the clock edge.
    task automatic check_model(input string tag);
        chk({tag, "_out_vld"}, 64'(out_vld), 64'(q.size() > 0));
        chk({tag, "_in_rdy"},  64'(in_rdy),  64'(q.size() < c_DEPTH));
        chk({tag, "_count"},   64'(count),   64'(q.size()));
        chk({tag, "_out_data"}, out_data, (q.size() > 0) ? q[0] : 64'd0);
        chk({tag, "_xfer_cnt"}, 64'(xfer_cnt), 64'(exp_xfer()));
    endtask

    // One clock cycle: check at the negedge, drive, apply the edge to the model.
    task automatic step(input string tag, input logic f, input logic iv,
                        input logic [63:0] d, input logic ordy);
        logic do_push, do_pop;
        check_model(tag);
        flush   = f;
        in_vld  = iv;
        in_data = d;
        out_rdy = ordy;
        do_push = iv && !f && (q.size() < c_DEPTH);
        do_pop  = ordy && !f && (q.size() > 0);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (do_push) q.push_back(d);
        end
        @(negedge clk);
        flush  = 1'b0;
        in_vld = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_vld", 64'(out_vld), 64'd0);
        chk("reset_in_rdy",  64'(in_rdy),  64'd1);
        chk("reset_count",   64'(count),   64'd0);
        chk("reset_xfer",    64'(xfer_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset with three beats stored and a transfer pending.
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b0, 1'b1, 64'hA0 + 64'(i), 1'b0);
        chk("rst_pre_count", 64'(count), 64'd3);
        in_vld  = 1'b1;
        in_data = 64'hDEAD;
        out_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_vld", 64'(out_vld), 64'd0);
        chk("async_count",   64'(count),   64'd0);
        chk("async_in_rdy",  64'(in_rdy),  64'd1);
        q.delete();
        n_pops = 0;
        @(negedge clk);
        in_vld = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 1'b0, 64'd0, 1'b1);

        // Fill to full, then a 5th beat is held off.
        step("fill", 1'b0, 1'b1, 64'h11, 1'b0);
        step("fill", 1'b0, 1'b1, 64'h22, 1'b0);
        step("fill", 1'b0, 1'b1, 64'h33, 1'b0);
        step("fill", 1'b0, 1'b1, 64'h44, 1'b0);
        chk("full_count",  64'(count),  64'd4);
        chk("full_in_rdy", 64'(in_rdy), 64'd0);
        step("held", 1'b0, 1'b1, 64'h55, 1'b0);
        chk("held_count", 64'(count), 64'd4);

        // Full with simultaneous pop: no write this cycle, write next cycle.
        step("full_pop", 1'b0, 1'b1, 64'h55, 1'b1);
        chk("full_pop_count",  64'(count),  64'd3);
        chk("full_pop_in_rdy", 64'(in_rdy), 64'd1);
        chk("full_pop_head",   out_data,    64'h22);
        step("accept", 1'b0, 1'b1, 64'h55, 1'b0);
        chk("accept_count", 64'(count), 64'd4);

        // Drain in order.
        chk("drain0", out_data, 64'h22);
        step("drain", 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain1", out_data, 64'h33);
        step("drain", 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain2", out_data, 64'h44);
        step("drain", 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain3", out_data, 64'h55);
        step("drain", 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drained_vld",   64'(out_vld), 64'd0);
        chk("drained_count", 64'(count),   64'd0);

        // Empty plus push and pop: only the push happens.
        step("empty_both", 1'b0, 1'b1, 64'h66, 1'b1);
        chk("empty_both_count", 64'(count), 64'd1);
        step("pre_sim", 1'b0, 1'b1, 64'h77, 1'b0);

        // Steady state at count 2 with push and pop every cycle.
        for (int i = 0; i < 10; i++) begin
            step("simul", 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
            chk("simul_count", 64'(count), 64'd2);
        end

        // Flush with a read pending is discarded and not counted.
        step("pre_flush", 1'b0, 1'b1, 64'h88, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd3);
        saved_xfer = xfer_cnt;
        step("flush", 1'b1, 1'b1, 64'h99, 1'b1);
        chk("flush_count",   64'(count),    64'd0);
        chk("flush_out_vld", 64'(out_vld),  64'd0);
        chk("flush_in_rdy",  64'(in_rdy),   64'd1);
        chk("flush_xfer",    64'(xfer_cnt), 64'(saved_xfer));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), 1'($urandom),
                 {$urandom, $urandom}, 1'($urandom));
        end
        check_model("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
